// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes, sequencer state encoding and the queued-write record
// for the LCD sequencer.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_LINE1   = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ISSUE, WAIT, WRAP} lcd_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_wr_t;

    // Power-up command list, issued in index order.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_DISPON;
            2'd2:    return LCD_CMD_ENTRY;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of {rs,data} LCD writes; DEPTH must be a power of two so the
// pointers wrap on their own.
module lcd_cmd_fifo
    import lcd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  lcd_wr_t wdata,
    input  logic    pop,
    output lcd_wr_t rdata,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    lcd_wr_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_cnt;
    logic           w_push;
    logic           w_pop;

    assign full   = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign rdata  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 power-up/init sequencer and write-queue drainer for the LCD driver.
// Define LCD_SEQ_AUTOWRAP_EN to track the cursor and auto-insert line-address commands.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int COLS           = 16,
    parameter int POWERUP_CYCLES = 750_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic        wr_rs,
    input  logic [7:0]  wr_data,
    output logic        drv_start,
    output logic [31:0] drv_dataa,
    output logic [31:0] drv_datab,
    input  logic        drv_done,
    output logic        init_done,
    output logic        busy
);
    localparam int CW = $clog2(POWERUP_CYCLES + 1);

    lcd_state_t     r_state;
    logic [CW-1:0]  r_pwr_cnt;
    logic [1:0]     r_init_idx;
    logic           r_start;
    logic           r_rs;
    logic [7:0]     r_byte;
    logic           r_init_done;

    lcd_wr_t        w_wr;
    lcd_wr_t        w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

`ifdef LCD_SEQ_AUTOWRAP_EN
    localparam int COLW = ($clog2(COLS + 1) > 4) ? $clog2(COLS + 1) : 4;
    localparam logic [COLW-1:0] COLS_L = COLW'(COLS);

    logic [COLW-1:0] r_col;
    logic            r_line;
    logic [COLW-1:0] w_addr_col;

    assign w_addr_col = COLW'(r_byte[3:0]);
`endif

    assign w_wr      = '{rs: wr_rs, data: wr_data};
    assign wr_ready  = ~w_full & r_init_done;
    assign w_push    = wr_valid & wr_ready;
    assign w_pop     = (r_state == IDLE) & ~w_empty;
    assign drv_start = r_start;
    assign drv_dataa = {31'b0, r_rs};
    assign drv_datab = {24'b0, r_byte};
    assign init_done = r_init_done;
    assign busy      = ~w_empty | ((r_state != PWRUP) & (r_state != IDLE));

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .wdata (w_wr),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= PWRUP;
            r_pwr_cnt   <= '0;
            r_init_idx  <= '0;
            r_start     <= 1'b0;
            r_rs        <= 1'b0;
            r_byte      <= '0;
            r_init_done <= 1'b0;
`ifdef LCD_SEQ_AUTOWRAP_EN
            r_col       <= '0;
            r_line      <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                PWRUP: begin
                    if (r_pwr_cnt == CW'(POWERUP_CYCLES - 1))
                        r_state <= INIT;
                    else
                        r_pwr_cnt <= r_pwr_cnt + 1'b1;
                end
                INIT: begin
                    r_start <= 1'b1;
                    r_rs    <= 1'b0;
                    r_byte  <= init_cmd(r_init_idx);
                    r_state <= ISSUE;
                end
                IDLE: begin
                    if (!w_empty) begin
                        r_start <= 1'b1;
                        r_rs    <= w_head.rs;
                        r_byte  <= w_head.data;
                        r_state <= ISSUE;
                    end
                end
                // dataa/datab stay in r_rs/r_byte until the done pulse
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (drv_done) begin
                        if (!r_init_done) begin
                            r_init_idx <= r_init_idx + 1'b1;
                            if (r_init_idx == 2'd3) begin
                                r_init_done <= 1'b1;
                                r_state     <= IDLE;
                            end else begin
                                r_state <= INIT;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
`ifdef LCD_SEQ_AUTOWRAP_EN
                        if (r_rs) begin
                            r_col <= r_col + 1'b1;
                            if (r_col + 1'b1 == COLS_L)
                                r_state <= WRAP;
                        end else if (r_byte == LCD_CMD_CLEAR || r_byte == LCD_CMD_HOME) begin
                            r_col  <= '0;
                            r_line <= 1'b0;
                        end else if (r_byte[7]) begin
                            r_line <= r_byte[6];
                            r_col  <= (w_addr_col >= COLS_L) ? COLS_L - 1'b1 : w_addr_col;
                        end
`endif
                    end
                end
`ifdef LCD_SEQ_AUTOWRAP_EN
                // The address command's own done resets col and flips line.
                WRAP: begin
                    r_start <= 1'b1;
                    r_rs    <= 1'b0;
                    r_byte  <= r_line ? LCD_CMD_LINE1 : LCD_CMD_LINE2;
                    r_state <= ISSUE;
                end
`endif
                default: r_state <= PWRUP;
            endcase
        end
    end

endmodule
